eeg_acc_cfg_port: RTL and testbench
===================================

Name: eeg_acc_cfg_port

Overview:
- Accelerator-side endpoint of the chip pad-buffer streams.
- Consumes the ACC_DAT stream (lst/cmd/dat beats) and decodes framed commands: register write, register read-back and sample streaming.
- Produces the ACC_OUT stream for read responses and exposes a flat configuration register bank.
- Sits between the pad buffer and the EEG compute core. It is the responder for the host-issued command stream.

Parameters:
- CHIP_DAT_DW, 8: width of ACC_DAT data beats and of each config register.
- CHIP_OUT_DW, 8: width of ACC_OUT data. Must be >= CHIP_DAT_DW; responses are zero-extended.
- REG_AW, 4: register address width. REG_NUM = 2**REG_AW registers.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ACC_DAT_VLD  in  1  input beat valid.
- ACC_DAT_LST  in  1  last beat of frame.
- ACC_DAT_RDY  out  1  input beat ready.
- ACC_DAT_DAT  in  CHIP_DAT_DW  input beat data.
- ACC_DAT_CMD  in  1  1 = header beat, 0 = payload beat.
- ACC_OUT_VLD  out  1  response beat valid.
- ACC_OUT_LST  out  1  last response beat.
- ACC_OUT_RDY  in  1  response ready.
- ACC_OUT_DAT  out  CHIP_OUT_DW  response data.
- SMP_VLD  out  1  sample beat valid.
- SMP_LST  out  1  last sample of frame.
- SMP_RDY  in  1  sample ready from core.
- SMP_DAT  out  CHIP_DAT_DW  sample data.
- CFG_REG  out  REG_NUM*CHIP_DAT_DW  flat register bank; reg i occupies bits [i*CHIP_DAT_DW +: CHIP_DAT_DW].
- ERR_FLAG  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Beat accepted when VLD && RDY (both streams).
- Header decode: dat[7:6] = opcode (00 WRITE, 01 READ, 10 STREAM, 11 reserved); dat[REG_AW-1:0] = start address.
- States: IDLE, WR, RD_LEN, RD_RESP, STREAM, DROP.
- Reset: state=IDLE, all registers 0, ERR_FLAG=0, ACC_OUT_VLD=0, ACC_OUT_LST=0, ACC_OUT_DAT=0, SMP_VLD=0, pointers/counters 0.
- ACC_DAT_RDY:
  - 1 in IDLE, WR, RD_LEN and DROP.
  - 0 in RD_RESP.
  - In STREAM, SMP_RDY passed combinationally.
- IDLE, header accepted:
  - WRITE -> WR; ptr = addr.
  - READ -> RD_LEN; ptr = addr.
  - STREAM -> STREAM.
  - Reserved -> DROP and set ERR_FLAG.
  - A header with lst=1 returns to IDLE. Zero-length WRITE/STREAM is legal. READ with lst=1 sets ERR_FLAG.
- IDLE, payload beat accepted: dropped, ERR_FLAG set.
- WR: each payload beat writes reg[ptr] at that edge, then ptr+1 mod REG_NUM (wraps 15->0 at default). lst returns to IDLE.
- RD_LEN: payload beat value L latched as count; response length is L+1 beats (1..256 at default).
  - lst=1 -> RD_RESP.
  - lst=0 -> ERR_FLAG set, DROP, no response.
- RD_RESP:
  - ACC_OUT_VLD=1 starting the cycle after the length beat is accepted.
  - ACC_OUT_DAT = zero-extended reg[ptr]; ACC_OUT_LST = (count==0). All outputs are held stable while RDY=0.
  - Each out handshake: ptr+1 mod REG_NUM, count-1.
  - Handshake with LST -> IDLE, VLD=0 next cycle.
  - Back-to-back handshakes give 1 beat per cycle.
- STREAM:
  - SMP_VLD = ACC_DAT_VLD && !ACC_DAT_CMD; SMP_DAT/SMP_LST pass through. Zero added latency, no buffering.
  - Accepted lst -> IDLE.
- DROP: payload beats consumed and discarded until lst -> IDLE.
- Header (cmd=1) arriving in WR, RD_LEN, STREAM or DROP:
  - Current frame aborted; ERR_FLAG set.
  - The beat is decoded as a new header in the same cycle.
  - In STREAM that header beat is not forwarded (SMP_VLD=0); RDY=1 for it regardless of SMP_RDY.
- Reset mid-frame: immediate return to reset state; registers cleared; a pending response is lost.
- Register writes and reads never coincide, because the input is stalled during RD_RESP.

Decomposition:
- Shared package eeg_acc_pkg holds:
  - Opcode constants OP_WRITE=2'b00, OP_READ=2'b01, OP_STREAM=2'b10, OP_RSVD=2'b11.
  - Header field positions.
  - State encoding.
- One sub-module: eeg_cfg_regfile, REG_NUM x CHIP_DAT_DW flops with write port, combinational read mux and flat output.
- The FSM and stream muxing stay in the top module.

Test Plan:
- Write then read-back: header 0x03 (WRITE addr 3), payload 0xA5, 0x5A (lst) -> CFG_REG reg3=0xA5, reg4=0x5A. Then header 0x43 plus length 0x01 (lst) -> ACC_OUT 0xA5, then 0x5A with LST=1, ERR_FLAG=0.
- Address wrap: WRITE addr 15 with 0x11, 0x22 (lst) -> reg15=0x11, reg0=0x22. READ addr 15, length 1 -> 0x11, 0x22.
- Back-pressure: READ addr 0, length 3 with ACC_OUT_RDY toggling 1,0,0,1,... -> 4 beats; DAT/LST held stable while stalled; ACC_DAT_RDY=0 throughout the response.
- Stream pass-through: header 0x80, payload 0x10, 0x20, 0x30 (lst) with SMP_RDY low for 2 cycles on 0x20 -> SMP sees 0x10, 0x20, 0x30 with LST on 0x30; ACC_DAT_RDY tracks SMP_RDY; returns to IDLE.
- Protocol errors:
  - Reserved header 0xC0 plus 2 payload beats -> dropped, ERR_FLAG=1, registers unchanged.
  - WRITE frame interrupted by a READ header -> earlier beats written, new frame decoded, ERR_FLAG=1.
  - Orphan payload in IDLE -> ERR_FLAG=1.
- Async reset during RD_RESP -> outputs low on the same edge, all registers 0, ERR_FLAG=0; a subsequent WRITE/READ works.

Source files
------------

// File: rtl/eeg_acc_pkg.sv
// Shared definitions for the accelerator configuration port.
//   - Header opcodes carried in the top two bits of a header beat.
//   - Bit positions of the opcode field inside a header beat.
//   - Encoding of the command-decoder states.
package eeg_acc_pkg;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_STREAM = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    // Opcode field of a header beat; the start address is in the low REG_AW bits.
    localparam int HDR_OP_HI = 7;
    localparam int HDR_OP_LO = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_LEN  = 3'd2,
        ST_RD_RESP = 3'd3,
        ST_STREAM  = 3'd4,
        ST_DROP    = 3'd5
    } acc_state_t;

endpackage

// File: rtl/eeg_cfg_regfile.sv
// Configuration register bank: 2**AW registers of DW bits.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears every register)
//   wr_en        write strobe; wr_data lands in register wr_addr at the edge
//   rd_addr      combinational read address, rd_data the selected register
//   cfg_flat     all registers side by side, register i at [i*DW +: DW]
module eeg_cfg_regfile #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DW-1:0]         wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DW-1:0]         rd_data,
    output logic [(2**AW)*DW-1:0] cfg_flat
);

    localparam int NUM = 2 ** AW;

    logic [DW-1:0] reg_arr [NUM];

    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_reg
            logic [DW-1:0] reg_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    reg_q <= '0;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    reg_q <= wr_data;
                end
            end

            assign reg_arr[gi]              = reg_q;
            assign cfg_flat[gi*DW +: DW]    = reg_q;
        end
    endgenerate

    assign rd_data = reg_arr[rd_addr];

endmodule

// File: rtl/eeg_acc_cfg_port.sv
// Accelerator-side endpoint of the pad-buffer streams.
// Decodes framed commands on ACC_DAT (register write, register read-back,
// sample streaming), returns read data on ACC_OUT, forwards sample payload
// to the compute core on SMP_*, and exposes the register bank as CFG_REG.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   ACC_DAT_{VLD,LST,RDY,DAT,CMD} command/payload input stream (CMD=1 header)
//   ACC_OUT_{VLD,LST,RDY,DAT}    read response stream (zero-extended data)
//   SMP_{VLD,LST,RDY,DAT}        sample stream to the core (pass-through)
//   CFG_REG                      flat register bank
//   ERR_FLAG                     sticky protocol error, cleared only by reset
module eeg_acc_cfg_port
    import eeg_acc_pkg::*;
#(
    parameter int CHIP_DAT_DW = 8,
    parameter int CHIP_OUT_DW = 8,
    parameter int REG_AW      = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ACC_DAT_VLD,
    input  logic                             ACC_DAT_LST,
    output logic                             ACC_DAT_RDY,
    input  logic [CHIP_DAT_DW-1:0]           ACC_DAT_DAT,
    input  logic                             ACC_DAT_CMD,
    output logic                             ACC_OUT_VLD,
    output logic                             ACC_OUT_LST,
    input  logic                             ACC_OUT_RDY,
    output logic [CHIP_OUT_DW-1:0]           ACC_OUT_DAT,
    output logic                             SMP_VLD,
    output logic                             SMP_LST,
    input  logic                             SMP_RDY,
    output logic [CHIP_DAT_DW-1:0]           SMP_DAT,
    output logic [(2**REG_AW)*CHIP_DAT_DW-1:0] CFG_REG,
    output logic                             ERR_FLAG
);

    acc_state_t             state_reg, state_next;
    logic [REG_AW-1:0]      ptr_reg, ptr_next;
    logic [CHIP_DAT_DW-1:0] cnt_reg, cnt_next;
    logic                   err_reg, err_next;

    logic                   wr_en;
    logic [CHIP_DAT_DW-1:0] rd_data;
    logic                   dat_rdy;
    logic                   smp_vld;
    logic                   resp_active;

    // Header decode, independent of the current state: a header beat is
    // always interpreted as the start of a new frame.
    logic [1:0]             hdr_op;
    logic [REG_AW-1:0]      hdr_addr;
    acc_state_t             hdr_state;
    logic                   hdr_err;

    assign hdr_op   = ACC_DAT_DAT[HDR_OP_HI:HDR_OP_LO];
    assign hdr_addr = ACC_DAT_DAT[REG_AW-1:0];

    always_comb begin
        hdr_state = ST_IDLE;
        hdr_err   = 1'b0;
        case (hdr_op)
            OP_WRITE:  hdr_state = ACC_DAT_LST ? ST_IDLE : ST_WR;
            OP_READ: begin
                // A read needs its length beat; a single-beat read frame is malformed.
                if (ACC_DAT_LST) begin
                    hdr_state = ST_IDLE;
                    hdr_err   = 1'b1;
                end else begin
                    hdr_state = ST_RD_LEN;
                end
            end
            OP_STREAM: hdr_state = ACC_DAT_LST ? ST_IDLE : ST_STREAM;
            OP_RSVD: begin
                hdr_state = ACC_DAT_LST ? ST_IDLE : ST_DROP;
                hdr_err   = 1'b1;
            end
            default: begin
                hdr_state = ST_IDLE;
                hdr_err   = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        wr_en      = 1'b0;
        dat_rdy    = 1'b0;
        smp_vld    = 1'b0;

        if (state_reg == ST_RD_RESP) begin
            // Input is stalled here, so the register bank is never written
            // while a response is being read out of it.
            if (ACC_OUT_RDY) begin
                ptr_next = ptr_reg + REG_AW'(1);
                cnt_next = cnt_reg - CHIP_DAT_DW'(1);
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end
            end
        end else if (ACC_DAT_VLD && ACC_DAT_CMD) begin
            // Header: accepted unconditionally (not forwarded to SMP); any
            // frame in progress is aborted and flagged.
            dat_rdy    = 1'b1;
            state_next = hdr_state;
            ptr_next   = hdr_addr;
            err_next   = err_reg | hdr_err | (state_reg != ST_IDLE);
        end else begin
            dat_rdy = (state_reg == ST_STREAM) ? SMP_RDY : 1'b1;
            smp_vld = (state_reg == ST_STREAM) && ACC_DAT_VLD;
            if (ACC_DAT_VLD && dat_rdy) begin
                case (state_reg)
                    ST_IDLE: err_next = 1'b1;
                    ST_WR: begin
                        wr_en    = 1'b1;
                        ptr_next = ptr_reg + REG_AW'(1);
                        if (ACC_DAT_LST) state_next = ST_IDLE;
                    end
                    ST_RD_LEN: begin
                        cnt_next = ACC_DAT_DAT;
                        if (ACC_DAT_LST) begin
                            state_next = ST_RD_RESP;
                        end else begin
                            state_next = ST_DROP;
                            err_next   = 1'b1;
                        end
                    end
                    ST_STREAM, ST_DROP: begin
                        if (ACC_DAT_LST) state_next = ST_IDLE;
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    eeg_cfg_regfile #(
        .DW (CHIP_DAT_DW),
        .AW (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (ptr_reg),
        .wr_data  (ACC_DAT_DAT),
        .rd_addr  (ptr_reg),
        .rd_data  (rd_data),
        .cfg_flat (CFG_REG)
    );

    // Response outputs derive from state/ptr/cnt only, so they stay stable
    // while the sink stalls and drop to zero as soon as reset asserts.
    assign resp_active = (state_reg == ST_RD_RESP);
    assign ACC_OUT_VLD = resp_active;
    assign ACC_OUT_LST = resp_active && (cnt_reg == '0);
    assign ACC_OUT_DAT = resp_active ? CHIP_OUT_DW'(rd_data) : '0;

    assign ACC_DAT_RDY = dat_rdy;
    assign SMP_VLD     = smp_vld;
    assign SMP_LST     = ACC_DAT_LST;
    assign SMP_DAT     = ACC_DAT_DAT;
    assign ERR_FLAG    = err_reg;

endmodule

// File: tb/tb_eeg_acc_cfg_port.sv
// Self-checking bench for eeg_acc_cfg_port: table of input beats with
// expected register/error state, scoreboard queues for ACC_OUT and SMP,
// plus hand-written back-pressure, streaming and async-reset sequences.
module tb_eeg_acc_cfg_port;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ACC_DAT_VLD = 1'b0;
    logic         ACC_DAT_LST = 1'b0;
    logic         ACC_DAT_RDY;
    logic [7:0]   ACC_DAT_DAT = 8'h00;
    logic         ACC_DAT_CMD = 1'b0;
    logic         ACC_OUT_VLD;
    logic         ACC_OUT_LST;
    logic         ACC_OUT_RDY = 1'b1;
    logic [7:0]   ACC_OUT_DAT;
    logic         SMP_VLD;
    logic         SMP_LST;
    logic         SMP_RDY = 1'b1;
    logic [7:0]   SMP_DAT;
    logic [127:0] CFG_REG;
    logic         ERR_FLAG;

    eeg_acc_cfg_port #(
        .CHIP_DAT_DW (8),
        .CHIP_OUT_DW (8),
        .REG_AW      (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ACC_DAT_VLD (ACC_DAT_VLD),
        .ACC_DAT_LST (ACC_DAT_LST),
        .ACC_DAT_RDY (ACC_DAT_RDY),
        .ACC_DAT_DAT (ACC_DAT_DAT),
        .ACC_DAT_CMD (ACC_DAT_CMD),
        .ACC_OUT_VLD (ACC_OUT_VLD),
        .ACC_OUT_LST (ACC_OUT_LST),
        .ACC_OUT_RDY (ACC_OUT_RDY),
        .ACC_OUT_DAT (ACC_OUT_DAT),
        .SMP_VLD     (SMP_VLD),
        .SMP_LST     (SMP_LST),
        .SMP_RDY     (SMP_RDY),
        .SMP_DAT     (SMP_DAT),
        .CFG_REG     (CFG_REG),
        .ERR_FLAG    (ERR_FLAG)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;      // pulse reset before this beat
        logic       cmd;
        logic       lst;
        logic [7:0] dat;
        logic       push;     // expected ACC_OUT beat to queue before the beat
        logic [7:0] pdat;
        logic       plst;
        int         chk_reg;  // register to check afterwards, -1 for none
        logic [7:0] chk_val;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] dat;
        logic       lst;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_out[$];
    exp_t exp_smp[$];

    int   n_cmp = 0;
    int   n_mis = 0;
    int   bp_mode = 0;        // 0: ACC_OUT_RDY=1, 1: pattern 1,0,0,1, 2: ACC_OUT_RDY=0
    int   bp_idx = 0;
    int   smp_stall_left = 0;
    logic in_stream = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic c, input logic l, input logic [7:0] d,
                       input logic p, input logic [7:0] pd, input logic pl,
                       input int cr, input logic [7:0] cv, input logic e);
        vec_t v;
        v.rst = r; v.cmd = c; v.lst = l; v.dat = d;
        v.push = p; v.pdat = pd; v.plst = pl;
        v.chk_reg = cr; v.chk_val = cv; v.exp_err = e;
        vecs.push_back(v);
    endtask

    task automatic push_out(input logic [7:0] d, input logic l);
        exp_t e;
        e.dat = d; e.lst = l;
        exp_out.push_back(e);
    endtask

    task automatic push_smp(input logic [7:0] d, input logic l);
        exp_t e;
        e.dat = d; e.lst = l;
        exp_smp.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drive one beat and hold it until the DUT accepts it (bounded).
    task automatic beat(input logic c, input logic l, input logic [7:0] d);
        int n;
        n = 0;
        @(posedge clk); #1;
        ACC_DAT_VLD = 1'b1; ACC_DAT_CMD = c; ACC_DAT_LST = l; ACC_DAT_DAT = d;
        forever begin
            @(negedge clk);
            if (ACC_DAT_RDY) break;
            n++;
            if (n > 300) begin
                n_cmp++; n_mis++;
                $display("FAIL beat_accept: got no RDY for beat %0h required RDY within 300 cycles", d);
                break;
            end
            @(posedge clk);
        end
        @(posedge clk); #1;
        ACC_DAT_VLD = 1'b0; ACC_DAT_CMD = 1'b0; ACC_DAT_LST = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_out.size() != 0 || exp_smp.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_out", exp_out.size(), 0);
        chk("drain_smp", exp_smp.size(), 0);
        @(negedge clk);
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (vecs[i].rst) do_reset();
            if (vecs[i].push) push_out(vecs[i].pdat, vecs[i].plst);
            beat(vecs[i].cmd, vecs[i].lst, vecs[i].dat);
            @(negedge clk);
            if (vecs[i].chk_reg >= 0)
                chk($sformatf("vec%0d_reg%0d", i, vecs[i].chk_reg),
                    CFG_REG[vecs[i].chk_reg*8 +: 8], vecs[i].chk_val);
            chk($sformatf("vec%0d_err", i), ERR_FLAG, vecs[i].exp_err);
            $display("vec %0d: cmd=%0b lst=%0b dat=%02h err=%0b", i,
                     vecs[i].cmd, vecs[i].lst, vecs[i].dat, ERR_FLAG);
        end
    endtask

    // Sink ready generators, updated after the input driver each cycle.
    initial forever begin
        @(posedge clk); #2;
        case (bp_mode)
            1: begin ACC_OUT_RDY = (bp_idx % 4 == 0) || (bp_idx % 4 == 3); bp_idx++; end
            2: ACC_OUT_RDY = 1'b0;
            default: ACC_OUT_RDY = 1'b1;
        endcase
        if (smp_stall_left > 0 && ACC_DAT_VLD && !ACC_DAT_CMD && ACC_DAT_DAT == 8'h20) begin
            SMP_RDY = 1'b0;
            smp_stall_left--;
        end else begin
            SMP_RDY = 1'b1;
        end
    end

    // Output monitor / scoreboard.
    logic       out_stall = 1'b0;
    logic [7:0] hold_dat = 8'h00;
    logic       hold_lst = 1'b0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            out_stall = 1'b0;
        end else begin
            if (out_stall) begin
                chk("out_hold_vld", ACC_OUT_VLD, 1'b1);
                chk("out_hold_dat", ACC_OUT_DAT, hold_dat);
                chk("out_hold_lst", ACC_OUT_LST, hold_lst);
            end
            if (ACC_OUT_VLD) chk("dat_rdy_low_in_resp", ACC_DAT_RDY, 1'b0);
            if (ACC_OUT_VLD && ACC_OUT_RDY) begin
                if (exp_out.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL out_unexpected: got beat %02h required no beat", ACC_OUT_DAT);
                end else begin
                    e = exp_out.pop_front();
                    chk("out_dat", ACC_OUT_DAT, e.dat);
                    chk("out_lst", ACC_OUT_LST, e.lst);
                    $display("out beat: dat=%02h lst=%0b", ACC_OUT_DAT, ACC_OUT_LST);
                end
            end
            out_stall = ACC_OUT_VLD && !ACC_OUT_RDY;
            hold_dat  = ACC_OUT_DAT;
            hold_lst  = ACC_OUT_LST;
            if (in_stream && ACC_DAT_VLD && !ACC_DAT_CMD)
                chk("dat_rdy_tracks_smp", ACC_DAT_RDY, SMP_RDY);
            if (SMP_VLD && SMP_RDY) begin
                if (exp_smp.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL smp_unexpected: got sample %02h required no sample", SMP_DAT);
                end else begin
                    e = exp_smp.pop_front();
                    chk("smp_dat", SMP_DAT, e.dat);
                    chk("smp_lst", SMP_LST, e.lst);
                    $display("smp beat: dat=%02h lst=%0b", SMP_DAT, SMP_LST);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // rst cmd lst dat  push pdat plst  chk  val    err
        add(0, 1, 0, 8'h03, 0, 8'h00, 0,  3, 8'h00, 0);  // 0  WRITE addr 3
        add(0, 0, 0, 8'hA5, 0, 8'h00, 0,  3, 8'hA5, 0);
        add(0, 0, 1, 8'h5A, 0, 8'h00, 0,  4, 8'h5A, 0);
        add(0, 1, 0, 8'h0F, 0, 8'h00, 0, 15, 8'h00, 0);  // 3  WRITE addr 15 (wrap)
        add(0, 0, 0, 8'h11, 0, 8'h00, 0, 15, 8'h11, 0);
        add(0, 0, 1, 8'h22, 0, 8'h00, 0,  0, 8'h22, 0);
        add(0, 1, 0, 8'h43, 1, 8'hA5, 0,  3, 8'hA5, 0);  // 6  READ addr 3
        add(0, 0, 1, 8'h01, 1, 8'h5A, 1, -1, 8'h00, 0);
        add(0, 1, 0, 8'h4F, 1, 8'h11, 0, -1, 8'h00, 0);  // 8  READ addr 15 (wrap)
        add(0, 0, 1, 8'h01, 1, 8'h22, 1, -1, 8'h00, 0);
        add(0, 1, 0, 8'hC0, 0, 8'h00, 0,  0, 8'h22, 1);  // 10 reserved header
        add(0, 0, 0, 8'h99, 0, 8'h00, 0,  0, 8'h22, 1);
        add(0, 0, 1, 8'h98, 0, 8'h00, 0,  3, 8'hA5, 1);
        add(1, 1, 0, 8'h05, 0, 8'h00, 0,  5, 8'h00, 0);  // 13 WRITE addr 5
        add(0, 0, 0, 8'h31, 0, 8'h00, 0,  5, 8'h31, 0);
        add(0, 1, 0, 8'h45, 1, 8'h31, 1,  5, 8'h31, 1);  // 15 READ header aborts WRITE
        add(0, 0, 1, 8'h00, 0, 8'h00, 0,  6, 8'h00, 1);
        add(1, 0, 0, 8'h55, 0, 8'h00, 0, -1, 8'h00, 1);  // 17 orphan payload in IDLE

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_vld", ACC_OUT_VLD, 1'b0);
        chk("rst_out_lst", ACC_OUT_LST, 1'b0);
        chk("rst_out_dat", ACC_OUT_DAT, 8'h00);
        chk("rst_smp_vld", SMP_VLD, 1'b0);
        chk("rst_cfg", CFG_REG, 128'h0);
        chk("rst_err", ERR_FLAG, 1'b0);
        chk("rst_dat_rdy", ACC_DAT_RDY, 1'b1);

        run_vecs(0, 9);
        wait_drain();

        // Back-pressure: READ addr 0, length 3 -> regs 0..3.
        push_out(8'h22, 0); push_out(8'h00, 0); push_out(8'h00, 0); push_out(8'hA5, 1);
        bp_idx = 0; bp_mode = 1;
        beat(1, 0, 8'h40);
        beat(0, 1, 8'h03);
        wait_drain();
        bp_mode = 0;

        // Stream pass-through with a 2-cycle stall on 0x20.
        push_smp(8'h10, 0); push_smp(8'h20, 0); push_smp(8'h30, 1);
        smp_stall_left = 2;
        in_stream = 1'b1;
        beat(1, 0, 8'h80);
        beat(0, 0, 8'h10);
        beat(0, 0, 8'h20);
        beat(0, 1, 8'h30);
        in_stream = 1'b0;
        wait_drain();
        chk("stream_no_err", ERR_FLAG, 1'b0);
        chk("stream_stall_used", smp_stall_left, 0);

        run_vecs(10, 17);
        wait_drain();

        // Async reset while a response is pending (sink stalled).
        bp_mode = 2;
        beat(1, 0, 8'h02);
        beat(0, 1, 8'h66);
        beat(1, 0, 8'h42);
        beat(0, 1, 8'h05);
        n = 0;
        while (!ACC_OUT_VLD && n < 20) begin @(negedge clk); n++; end
        chk("resp_pending_vld", ACC_OUT_VLD, 1'b1);
        chk("resp_pending_dat", ACC_OUT_DAT, 8'h66);
        chk("pre_reset_err", ERR_FLAG, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_vld", ACC_OUT_VLD, 1'b0);
        chk("arst_out_lst", ACC_OUT_LST, 1'b0);
        chk("arst_out_dat", ACC_OUT_DAT, 8'h00);
        chk("arst_cfg", CFG_REG, 128'h0);
        chk("arst_err", ERR_FLAG, 1'b0);
        exp_out.delete();
        bp_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Traffic after reset.
        beat(1, 0, 8'h01);
        beat(0, 1, 8'h42);
        push_out(8'h42, 1);
        beat(1, 0, 8'h41);
        beat(0, 1, 8'h00);
        wait_drain();
        chk("post_reset_reg1", CFG_REG[15:8], 8'h42);
        chk("post_reset_err", ERR_FLAG, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
